wvb_rd_arbiter: RTL and testbench

- Round-robin arbiter that shares one wvb_reader between N_CHANNELS waveform_buffer instances.
- Scans the per-channel hdr_empty flags and grants one channel at a time.
- Routes the reader's hdr_rdreq/wvb_rdreq/wvb_rddone strobes to the granted buffer only, and muxes that buffer's header and waveform data back to the reader.
- Sits between the waveform_buffer array and wvb_reader on the readout path.

---
 rtl/wvb_rd_arbiter_pkg.sv | 30 +++
 rtl/wvb_rd_arbiter_prio.sv | 32 +++
 rtl/wvb_rd_arbiter.sv | 122 ++++++++++++
 tb/tb_wvb_rd_arbiter.sv | 427 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wvb_rd_arbiter_pkg.sv
// Shared types and helpers for the waveform-buffer read arbiter.
// State encodings, index-width helper and packed-bus slice macros.
`ifndef WVB_RD_ARBITER_PKG_SV
`define WVB_RD_ARBITER_PKG_SV

`define WVB_HDR_SLICE(bus, idx, w) bus[(idx)*(w) +: (w)]
`define WVB_DATA_SLICE(bus, idx, w) bus[(idx)*(w) +: (w)]

package wvb_rd_arbiter_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_GAP   = 2'd2
    } state_e;

    function automatic int clog2(input int n);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

`endif

// File: rtl/wvb_rd_arbiter_prio.sv
// Rotate-from-pointer priority encoder.
// Returns the first set request strictly after ptr_i, wrapping at N.
module rr_prio_enc
    import wvb_rd_arbiter_pkg::*;
#(
    parameter int N = 24,
    parameter int W = 5
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] ptr_i,
    output logic [W-1:0] idx_o,
    output logic         valid_o
);

    // Walk backwards so the closest request after the pointer wins.
    always_comb begin
        int pos;
        idx_o   = '0;
        valid_o = 1'b0;
        pos     = 0;
        for (int k = N; k >= 1; k--) begin
            pos = int'(ptr_i) + k;
            if (pos >= N) pos = pos - N;
            if (pos >= N) pos = pos - N;
            if (req_i[pos]) begin
                idx_o   = W'(pos);
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wvb_rd_arbiter.sv
// Round-robin arbiter sharing one wvb_reader across N waveform buffers.
// Strobes route to the granted buffer; its header/data mux back.
module wvb_rd_arbiter
    import wvb_rd_arbiter_pkg::*;
#(
    parameter int N_CHANNELS   = 24,
    parameter int P_IDX_WIDTH  = 5,
    parameter int P_HDR_WIDTH  = 80,
    parameter int P_DATA_WIDTH = 22
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               en,
    input  logic [N_CHANNELS-1:0]              chan_en,
    input  logic [N_CHANNELS-1:0]              hdr_empty_in,
    input  logic [N_CHANNELS*P_HDR_WIDTH-1:0]  hdr_data_in,
    input  logic [N_CHANNELS*P_DATA_WIDTH-1:0] wvb_data_in,
    output logic [N_CHANNELS-1:0]              hdr_rdreq_out,
    output logic [N_CHANNELS-1:0]              wvb_rdreq_out,
    output logic [N_CHANNELS-1:0]              wvb_rddone_out,
    input  logic                               rd_hdr_rdreq,
    input  logic                               rd_wvb_rdreq,
    input  logic                               rd_wvb_rddone,
    output logic                               rd_hdr_empty,
    output logic [P_HDR_WIDTH-1:0]             rd_hdr_data,
    output logic [P_DATA_WIDTH-1:0]            rd_wvb_data,
    output logic [P_IDX_WIDTH-1:0]             rd_chan,
    output logic                               busy,
    output logic                               stray_err,
    output logic [31:0]                        n_grants
);

    localparam logic [N_CHANNELS-1:0] ONE = N_CHANNELS'(1);

    state_e                 state_q, state_d;
    logic [P_IDX_WIDTH-1:0] grant_q, grant_d;
    logic [P_IDX_WIDTH-1:0] last_q, last_d;
    logic                   stray_q, stray_d;
    logic [31:0]            ngr_q, ngr_d;

    logic [N_CHANNELS-1:0]  req;
    logic [P_IDX_WIDTH-1:0] sel_idx;
    logic                   sel_vld;
    logic                   active;
    logic                   any_strobe;

    assign req = ~hdr_empty_in & chan_en;

    rr_prio_enc #(
        .N (N_CHANNELS),
        .W (P_IDX_WIDTH)
    ) u_enc (
        .req_i   (req),
        .ptr_i   (last_q),
        .idx_o   (sel_idx),
        .valid_o (sel_vld)
    );

    // A grant stops forwarding in the reset cycle itself.
    assign active     = (state_q == S_GRANT) & ~rst;
    assign any_strobe = rd_hdr_rdreq | rd_wvb_rdreq | rd_wvb_rddone;

    assign hdr_rdreq_out  = (active & rd_hdr_rdreq)  ? (ONE << grant_q) : '0;
    assign wvb_rdreq_out  = (active & rd_wvb_rdreq)  ? (ONE << grant_q) : '0;
    assign wvb_rddone_out = (active & rd_wvb_rddone) ? (ONE << grant_q) : '0;

    assign rd_hdr_empty = active ? hdr_empty_in[grant_q] : 1'b1;
    assign rd_hdr_data  = `WVB_HDR_SLICE(hdr_data_in, grant_q, P_HDR_WIDTH);
    assign rd_wvb_data  = `WVB_DATA_SLICE(wvb_data_in, grant_q, P_DATA_WIDTH);
    assign rd_chan      = grant_q;
    assign busy         = active;
    assign stray_err    = stray_q;
    assign n_grants     = ngr_q;

    // Next-state: grant in IDLE, release on rddone, one-cycle settle gap.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        ngr_d   = ngr_q;
        stray_d = stray_q | (any_strobe & (state_q != S_GRANT));
        unique case (state_q)
            S_IDLE: begin
                if (en && sel_vld) begin
                    grant_d = sel_idx;
                    ngr_d   = ngr_q + 32'd1;
                    state_d = S_GRANT;
                end
            end
            S_GRANT: begin
                if (rd_wvb_rddone) begin
                    last_d  = grant_q;
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            last_q  <= P_IDX_WIDTH'(N_CHANNELS - 1);
            stray_q <= 1'b0;
            ngr_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            stray_q <= stray_d;
            ngr_q   <= ngr_d;
        end
    end

endmodule

// File: tb/tb_wvb_rd_arbiter.sv
// Self-checking bench for wvb_rd_arbiter.
// Buffers and reader are modelled here; grant order from a cyclic-search model.
module tb_wvb_rd_arbiter;

    localparam int N  = 24;
    localparam int HW = 80;
    localparam int DW = 22;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            en = 1'b0;
    logic [N-1:0]    chan_en = '1;
    logic [N-1:0]    hdr_empty_in = '1;
    logic [N*HW-1:0] hdr_data_in = '0;
    logic [N*DW-1:0] wvb_data_in = '0;
    logic [N-1:0]    hdr_rdreq_out, wvb_rdreq_out, wvb_rddone_out;
    logic            rd_hdr_rdreq = 1'b0;
    logic            rd_wvb_rdreq = 1'b0;
    logic            rd_wvb_rddone = 1'b0;
    logic            rd_hdr_empty;
    logic [HW-1:0]   rd_hdr_data;
    logic [DW-1:0]   rd_wvb_data;
    logic [4:0]      rd_chan;
    logic            busy, stray_err;
    logic [31:0]     n_grants;

    int total = 0;
    int bad = 0;
    int pending[N];
    int last_m = N - 1;
    int ngr = 0;

    wvb_rd_arbiter dut (
        .clk(clk), .rst(rst), .en(en), .chan_en(chan_en),
        .hdr_empty_in(hdr_empty_in), .hdr_data_in(hdr_data_in),
        .wvb_data_in(wvb_data_in), .hdr_rdreq_out(hdr_rdreq_out),
        .wvb_rdreq_out(wvb_rdreq_out), .wvb_rddone_out(wvb_rddone_out),
        .rd_hdr_rdreq(rd_hdr_rdreq), .rd_wvb_rdreq(rd_wvb_rdreq),
        .rd_wvb_rddone(rd_wvb_rddone), .rd_hdr_empty(rd_hdr_empty),
        .rd_hdr_data(rd_hdr_data), .rd_wvb_data(rd_wvb_data),
        .rd_chan(rd_chan), .busy(busy), .stray_err(stray_err),
        .n_grants(n_grants)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    function automatic logic [HW-1:0] hdr_of(input int c);
        return {8'(c), 8'(pending[c]), 32'hC0DE0000 ^ 32'(c * 12345), 32'(c * 7 + 1)};
    endfunction

    function automatic logic [N-1:0] onehot(input int c);
        logic [N-1:0] v;
        v = '0;
        v[c] = 1'b1;
        return v;
    endfunction

    // Next channel after last_m (cyclic) that has a waveform and is enabled.
    function automatic int pick();
        int c;
        for (int k = 1; k <= N; k++) begin
            c = (last_m + k) % N;
            if (pending[c] > 0 && chan_en[c]) return c;
        end
        return -1;
    endfunction

    task automatic upd();
        for (int i = 0; i < N; i++) begin
            hdr_empty_in[i] = (pending[i] == 0);
            hdr_data_in[i*HW +: HW] = hdr_of(i);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        last_m = N - 1;
        ngr = 0;
    endtask

    task automatic wait_grant(input int ch, output int w);
        w = 0;
        @(negedge clk);
        while (busy !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        ngr++;
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL grant_wait ch=%0d busy=%b want 1", ch, busy);
        end
        total++;
        if (rd_chan !== 5'(ch)) begin
            bad++;
            $display("FAIL grant_chan got=%0d want=%0d", rd_chan, ch);
        end
        total++;
        if (n_grants !== 32'(ngr)) begin
            bad++;
            $display("FAIL n_grants got=%0d want=%0d", n_grants, ngr);
        end
        total++;
        if (rd_hdr_empty !== 1'b0) begin
            bad++;
            $display("FAIL hdr_empty_grant ch=%0d got=%b want 0", ch, rd_hdr_empty);
        end
        total++;
        if (rd_hdr_data !== hdr_of(ch)) begin
            bad++;
            $display("FAIL hdr_data ch=%0d got=%h want=%h", ch, rd_hdr_data, hdr_of(ch));
        end
    endtask

    task automatic read_body(input int ch, input int ns, input int drop_at);
        logic [DW-1:0] e;
        rd_hdr_rdreq = 1'b1;
        #1;
        total++;
        if (hdr_rdreq_out !== onehot(ch)) begin
            bad++;
            $display("FAIL hdr_rdreq got=%h want=%h", hdr_rdreq_out, onehot(ch));
        end
        @(negedge clk);
        rd_hdr_rdreq = 1'b0;
        for (int s = 0; s < ns; s++) begin
            if (s == drop_at) en = 1'b0;
            for (int i = 0; i < N; i++) wvb_data_in[i*DW +: DW] = DW'($urandom);
            e = wvb_data_in[ch*DW +: DW];
            rd_wvb_rdreq = 1'b1;
            #1;
            total++;
            if (wvb_rdreq_out !== onehot(ch) || rd_wvb_data !== e) begin
                bad++;
                $display("FAIL wvb_read s=%0d req=%h want=%h data=%h want=%h",
                         s, wvb_rdreq_out, onehot(ch), rd_wvb_data, e);
            end
            @(negedge clk);
        end
        rd_wvb_rdreq  = 1'b0;
        rd_wvb_rddone = 1'b1;
        #1;
        total++;
        if (wvb_rddone_out !== onehot(ch)) begin
            bad++;
            $display("FAIL rddone got=%h want=%h", wvb_rddone_out, onehot(ch));
        end
        @(negedge clk);
        rd_wvb_rddone = 1'b0;
        pending[ch]--;
        upd();
        last_m = ch;
        total++;
        if (busy !== 1'b0 || rd_hdr_empty !== 1'b1 || wvb_rddone_out !== '0) begin
            bad++;
            $display("FAIL gap busy=%b empty=%b done=%h want 0/1/0",
                     busy, rd_hdr_empty, wvb_rddone_out);
        end
    endtask

    task automatic read_one(input int ch, input int ns, input int drop_at);
        int w;
        wait_grant(ch, w);
        read_body(ch, ns, drop_at);
    endtask

    task automatic test_reset();
        for (int i = 0; i < N; i++) pending[i] = 0;
        upd();
        do_reset();
        total++;
        if (hdr_rdreq_out !== '0 || wvb_rdreq_out !== '0 || wvb_rddone_out !== '0 ||
            rd_hdr_empty !== 1'b1 || rd_chan !== 5'd0 || busy !== 1'b0 ||
            stray_err !== 1'b0 || n_grants !== 32'd0) begin
            bad++;
            $display("FAIL reset_state empty=%b chan=%0d busy=%b stray=%b ng=%0d",
                     rd_hdr_empty, rd_chan, busy, stray_err, n_grants);
        end
    endtask

    task automatic test_basic();
        en = 1'b1;
        pending[0] = 1;
        pending[5] = 1;
        pending[23] = 1;
        upd();
        read_one(0, 11, -1);
        read_one(5, 11, -1);
        read_one(23, 11, -1);
        total++;
        if (n_grants !== 32'd3) begin
            bad++;
            $display("FAIL basic_count got=%0d want=3", n_grants);
        end
    endtask

    task automatic test_wrap();
        pending[5] = 1;
        upd();
        read_one(5, 2, -1);
        pending[3] = 1;
        pending[7] = 1;
        upd();
        read_one(7, 2, -1);
        read_one(3, 2, -1);
    endtask

    task automatic test_mask();
        int w;
        chan_en = 24'hFFFFFE;
        pending[0] = 1;
        upd();
        repeat (6) begin
            @(negedge clk);
            total++;
            if (busy !== 1'b0 || rd_hdr_empty !== 1'b1) begin
                bad++;
                $display("FAIL masked busy=%b empty=%b want 0/1", busy, rd_hdr_empty);
            end
        end
        chan_en[0] = 1'b1;
        wait_grant(0, w);
        total++;
        if (w > 1) begin
            bad++;
            $display("FAIL mask_latency got=%0d want<=1", w);
        end
        read_body(0, 3, -1);
    endtask

    task automatic test_back_to_back();
        int w;
        pending[2] = 2;
        upd();
        read_one(2, 2, -1);
        @(negedge clk);
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL b2b_idle busy=%b want 0", busy);
        end
        wait_grant(2, w);
        total++;
        if (w !== 0) begin
            bad++;
            $display("FAIL b2b_turnaround extra=%0d want 0", w);
        end
        read_body(2, 2, -1);
    endtask

    task automatic test_hdr_rise();
        int w;
        pending[11] = 1;
        upd();
        wait_grant(11, w);
        hdr_empty_in[11] = 1'b1;
        #1;
        total++;
        if (rd_hdr_empty !== 1'b1) begin
            bad++;
            $display("FAIL hdr_rise empty=%b want 1", rd_hdr_empty);
        end
        repeat (3) @(negedge clk);
        total++;
        if (busy !== 1'b1 || rd_chan !== 5'd11) begin
            bad++;
            $display("FAIL hdr_rise_hold busy=%b chan=%0d want 1/11", busy, rd_chan);
        end
        upd();
        read_body(11, 2, -1);
    endtask

    task automatic test_stray();
        @(negedge clk);
        rd_wvb_rdreq = 1'b1;
        #1;
        total++;
        if (wvb_rdreq_out !== '0) begin
            bad++;
            $display("FAIL stray_fwd got=%h want 0", wvb_rdreq_out);
        end
        @(negedge clk);
        rd_wvb_rdreq = 1'b0;
        total++;
        if (stray_err !== 1'b1) begin
            bad++;
            $display("FAIL stray_set got=%b want 1", stray_err);
        end
        repeat (4) @(negedge clk);
        total++;
        if (stray_err !== 1'b1) begin
            bad++;
            $display("FAIL stray_sticky got=%b want 1", stray_err);
        end
        do_reset();
        total++;
        if (stray_err !== 1'b0) begin
            bad++;
            $display("FAIL stray_clear got=%b want 0", stray_err);
        end
    endtask

    task automatic test_en_drop();
        pending[4] = 1;
        pending[9] = 1;
        upd();
        read_one(4, 1035, 500);
        repeat (10) begin
            @(negedge clk);
            total++;
            if (busy !== 1'b0 || n_grants !== 32'(ngr)) begin
                bad++;
                $display("FAIL en_off busy=%b ng=%0d want 0/%0d", busy, n_grants, ngr);
            end
        end
        en = 1'b1;
        read_one(9, 2, -1);
    endtask

    task automatic test_random();
        int c;
        for (int g = 0; g < 40; g++) begin
            if (pick() < 0) begin
                for (int i = 0; i < N; i++) pending[i] = $urandom_range(0, 2);
                chan_en = N'($urandom);
                upd();
            end
            c = pick();
            if (c >= 0) read_one(c, $urandom_range(1, 4), -1);
        end
        chan_en = '0;
        repeat (4) begin
            @(negedge clk);
            total++;
            if (busy !== 1'b0) begin
                bad++;
                $display("FAIL rand_masked busy=%b want 0", busy);
            end
        end
    endtask

    task automatic test_fair();
        int cnt[N];
        int lastg[N];
        int maxgap;
        int c;
        maxgap = 0;
        for (int i = 0; i < N; i++) begin
            pending[i] = 9;
            cnt[i] = 0;
            lastg[i] = -1;
        end
        chan_en = '1;
        upd();
        for (int g = 0; g < 200; g++) begin
            c = pick();
            read_one(c, 1, -1);
            cnt[c]++;
            if (lastg[c] >= 0 && g - lastg[c] - 1 > maxgap) maxgap = g - lastg[c] - 1;
            lastg[c] = g;
        end
        for (int i = 0; i < N; i++) begin
            total++;
            if (cnt[i] < 8 || cnt[i] > 9) begin
                bad++;
                $display("FAIL fair_count ch=%0d got=%0d want 8..9", i, cnt[i]);
            end
        end
        total++;
        if (maxgap > N - 1) begin
            bad++;
            $display("FAIL fair_gap got=%0d want<=%0d", maxgap, N - 1);
        end
    endtask

    task automatic test_rst_in_grant();
        int w;
        wait_grant(pick(), w);
        rst = 1'b1;
        rd_hdr_rdreq = 1'b1;
        rd_wvb_rdreq = 1'b1;
        #1;
        total++;
        if (hdr_rdreq_out !== '0 || wvb_rdreq_out !== '0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL rst_grant hdr=%h wvb=%h busy=%b want 0", hdr_rdreq_out,
                     wvb_rdreq_out, busy);
        end
        @(negedge clk);
        rst = 1'b0;
        rd_hdr_rdreq = 1'b0;
        rd_wvb_rdreq = 1'b0;
        total++;
        if (busy !== 1'b0 || rd_chan !== 5'd0 || n_grants !== 32'd0 || stray_err !== 1'b0) begin
            bad++;
            $display("FAIL rst_after busy=%b chan=%0d ng=%0d stray=%b want 0",
                     busy, rd_chan, n_grants, stray_err);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_mask();
        test_back_to_back();
        test_hdr_rise();
        test_stray();
        test_en_drop();
        test_random();
        test_fair();
        test_rst_in_grant();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
